ldst_unit: RTL
==============

Name: ldst_unit

Overview:
Memory-access stage directly downstream of the IEU. Takes the IEU's registered outputs and issues loads and stores on a req/gnt/rvalid data-memory bus. Handles byte-lane alignment of store data, and byte extraction with sign/zero extension of load data. Drives a stall back to the pipeline while an access is in flight, and registers results and write-back controls for the WBU.

Parameters:
DataWidth, 32, data and address width
RegAddrWidth, 5, register-file index width

Ports:
brq_clk  in  1  clock; one clock domain only
brq_rst  in  1  reset; synchronous, active-high
ieu_mem_addr  in  DataWidth  byte address from the ALU
ieu_store_data  in  DataWidth  rs2 value for stores
ieu_func3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
ieu_mem_ren  in  1  load request
ieu_mem_wen  in  1  store request
ieu_memtoreg  in  1  write-back selects memory data
ieu_regfile_en  in  1  instruction writes rd
ieu_addr_dst  in  RegAddrWidth  rd index
ieu_alu_result_dealy  in  DataWidth  ALU result for non-load write-back
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_be  out  4  byte enables
dmem_addr  out  DataWidth  word-aligned address, {addr[31:2],2'b00}
dmem_wdata  out  DataWidth  lane-aligned store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  DataWidth  read data
ldst_stall  out  1  freeze upstream stages
ldst_regfile_en  out  1  to WBU and forwarding unit
ldst_addr_dst  out  RegAddrWidth  to WBU
ldst_memtoreg  out  1  to WBU
ldst_mem_result  out  DataWidth  extended load data
ldst_alu_result  out  DataWidth  registered copy of ieu_alu_result_dealy
ldst_misaligned  out  1  misalignment pulse; present only with the optional feature

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs are 0.
  - dmem_req = 0 and ldst_stall = 0.
  - Any dmem_rvalid arriving after reset is ignored.
  - Reset mid-access abandons the access; no write-back is produced.
- Non-memory instruction: ren = wen = 0. Pass-through with 1-cycle latency; never stalls.
- Simultaneous ren and wen: the load wins and wen is ignored.
- FSM states: IDLE, REQ, WAIT_RD.
  - IDLE, memory op present: request is latched internally (addr, func3, wdata, be, rd, controls) and dmem_req is driven combinationally from the inputs the same cycle.
    - Store with gnt: completes; back-to-back allowed, no stall.
    - Load with gnt: go to WAIT_RD.
    - No gnt: go to REQ.
  - REQ: dmem_req held high with the latched values, which stay stable until gnt. On gnt: store goes to IDLE (complete); load goes to WAIT_RD.
  - WAIT_RD: dmem_req = 0. On rvalid: format rdata, register it, go to IDLE.
- Stall: ldst_stall = 1 in every cycle where a memory op is present or pending and does not complete that cycle. Completion means store gnt, or load rvalid. Combinational, deasserts in the completing cycle.
  - Load best case (gnt in the issue cycle, rvalid next cycle): 1 stall cycle.
- Bubbles: any cycle in which nothing completes registers ldst_regfile_en = 0 for the next cycle.
- Store alignment, using lanes from addr[1:0]:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated 4x.
  - SH: be = 0011 << (2*addr[1]); wdata = halfword replicated 2x.
  - SW: be = 1111.
- Load extraction:
  - LB/LBU: byte at lane addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
  - Undefined func3 (011, 110, 111): treated as LW / SW.
- Stores: ldst_regfile_en follows ieu_regfile_en, which is 0 for stores.

Optional Feature:
BRQ_LDST_MISALIGN_TRAP_EN
- Defined:
  - An LH/LHU/SH with addr[0] = 1, or an LW/SW with addr[1:0] != 0, issues no bus request and causes no stall.
  - ldst_misaligned pulses for 1 cycle, registered alongside the bubble.
  - ldst_regfile_en = 0 for that instruction.
- Undefined:
  - Port removed.
  - Low address bits below the access size are ignored: access is forced to natural alignment (half via addr[1], word at addr[31:2]).

Decomposition:
- Package brq_ldst_pkg: func3 enum (LB, LH, LW, LBU, LHU), FSM state enum, DataWidth/byte-count constants.
- Sub-module ldst_align (combinational), two functions:
  - Store side: func3 + addr[1:0] + data -> be + wdata.
  - Load side: func3 + addr[1:0] + rdata -> extended result.
- The FSM and pipeline registers stay in ldst_unit.

Test Plan:
1. Add instruction, ieu_alu_result_dealy = 0x1234, rd = 5, regfile_en = 1 -> next cycle ldst_alu_result = 0x1234, ldst_addr_dst = 5, ldst_regfile_en = 1, stall never high.
2. SB addr 0x103, data 0xAB, gnt same cycle -> dmem_be = 1000, dmem_wdata = 0xABABABAB, dmem_addr = 0x100, no stall.
3. LB addr 0x102, gnt immediate, rvalid next cycle with rdata 0x0080FF00 -> ldst_mem_result = 0xFFFFFF80, 1 stall cycle; repeat as LBU -> 0x00000080.
4. LHU addr 0x202, gnt delayed 3 cycles, rvalid 2 cycles later, rdata 0xBEEF0000 -> dmem_req/addr stable for 4 cycles, stall for 5 cycles, result 0x0000BEEF, regfile_en = 0 bubbles during the stall.
5. Load in WAIT_RD, brq_rst asserted for 1 cycle, rvalid arrives after reset -> no write-back, state IDLE, all outputs 0.
6. With BRQ_LDST_MISALIGN_TRAP_EN defined: LW addr 0x301 -> dmem_req stays 0, ldst_misaligned = 1 for one cycle, ldst_regfile_en = 0.

Source files
------------

// File: rtl/brq_ldst_pkg.sv
// Shared types and helpers for the load/store stage: func3 codes, FSM states,
// access-size decode and the natural-alignment test.
package brq_ldst_pkg;

    localparam int DATA_W         = 32;
    localparam int BYTES_PER_WORD = DATA_W / 8;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } func3_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // The unused codes 011, 110 and 111 all land on word.
    function automatic size_e acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic acc_unsigned(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic acc_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (acc_size(f3))
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ldst_align.sv
// Byte-lane steering: store data/byte-enables toward the bus and load data
// extraction with sign/zero extension back from it. Purely combinational.
module ldst_align
    import brq_ldst_pkg::*;
(
    input  logic [2:0]                i_st_func3,
    input  logic [1:0]                i_st_addr_lo,
    input  logic [DATA_W-1:0]         i_st_data,
    output logic [BYTES_PER_WORD-1:0] o_st_be,
    output logic [DATA_W-1:0]         o_st_wdata,
    input  logic [2:0]                i_ld_func3,
    input  logic [1:0]                i_ld_addr_lo,
    input  logic [DATA_W-1:0]         i_ld_rdata,
    output logic [DATA_W-1:0]         o_ld_result
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic        w_ld_unsigned;

    always_comb begin
        o_st_be    = 4'b1111;
        o_st_wdata = i_st_data;
        case (acc_size(i_st_func3))
            SZ_BYTE: begin
                o_st_be    = 4'b0001 << i_st_addr_lo;
                o_st_wdata = {4{i_st_data[7:0]}};
            end
            SZ_HALF: begin
                o_st_be    = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_wdata = {2{i_st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (i_ld_addr_lo)
            2'd0:    w_ld_byte = i_ld_rdata[7:0];
            2'd1:    w_ld_byte = i_ld_rdata[15:8];
            2'd2:    w_ld_byte = i_ld_rdata[23:16];
            default: w_ld_byte = i_ld_rdata[31:24];
        endcase
        w_ld_half     = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
        w_ld_unsigned = acc_unsigned(i_ld_func3);
        case (acc_size(i_ld_func3))
            SZ_BYTE: o_ld_result = w_ld_unsigned ? {24'b0, w_ld_byte}
                                                 : {{24{w_ld_byte[7]}}, w_ld_byte};
            SZ_HALF: o_ld_result = w_ld_unsigned ? {16'b0, w_ld_half}
                                                 : {{16{w_ld_half[15]}}, w_ld_half};
            default: o_ld_result = i_ld_rdata;
        endcase
    end

endmodule

// File: rtl/ldst_unit.sv
// Memory-access stage: issues IEU loads/stores on a req/gnt/rvalid bus, stalls
// the pipe while in flight. BRQ_LDST_MISALIGN_TRAP_EN adds a misalignment trap.
//   state      | meaning
//   ST_IDLE    | no access pending; a new memory op is issued straight from inputs
//   ST_REQ     | request held on the bus from latched values, waiting for gnt
//   ST_WAIT_RD | load granted, waiting for rvalid
module ldst_unit
    import brq_ldst_pkg::*;
#(
    parameter int DataWidth    = 32,
    parameter int RegAddrWidth = 5
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst,
    input  logic [DataWidth-1:0]    ieu_mem_addr,
    input  logic [DataWidth-1:0]    ieu_store_data,
    input  logic [2:0]              ieu_func3,
    input  logic                    ieu_mem_ren,
    input  logic                    ieu_mem_wen,
    input  logic                    ieu_memtoreg,
    input  logic                    ieu_regfile_en,
    input  logic [RegAddrWidth-1:0] ieu_addr_dst,
    input  logic [DataWidth-1:0]    ieu_alu_result_dealy,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [3:0]              dmem_be,
    output logic [DataWidth-1:0]    dmem_addr,
    output logic [DataWidth-1:0]    dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [DataWidth-1:0]    dmem_rdata,
    output logic                    ldst_stall,
    output logic                    ldst_regfile_en,
    output logic [RegAddrWidth-1:0] ldst_addr_dst,
    output logic                    ldst_memtoreg,
    output logic [DataWidth-1:0]    ldst_mem_result,
    output logic [DataWidth-1:0]    ldst_alu_result
`ifdef BRQ_LDST_MISALIGN_TRAP_EN
    ,
    output logic                    ldst_misaligned
`endif
);

    state_e                  r_state, w_state_nxt;

    logic [DataWidth-1:0]    r_lat_addr;
    logic [2:0]              r_lat_func3;
    logic [DataWidth-1:0]    r_lat_wdata;
    logic [3:0]              r_lat_be;
    logic                    r_lat_load;
    logic                    r_lat_regfile_en;
    logic                    r_lat_memtoreg;
    logic [RegAddrWidth-1:0] r_lat_rd;
    logic [DataWidth-1:0]    r_lat_alu;

    logic                    r_regfile_en;
    logic [RegAddrWidth-1:0] r_addr_dst;
    logic                    r_memtoreg;
    logic [DataWidth-1:0]    r_mem_result;
    logic [DataWidth-1:0]    r_alu_result;

    logic                    w_mem_op, w_is_load, w_trap, w_issue;
    logic [3:0]              w_st_be;
    logic [DataWidth-1:0]    w_st_wdata, w_ld_result;
    logic                    w_req, w_we, w_stall;
    logic [3:0]              w_be;
    logic [DataWidth-1:0]    w_addr, w_wdata;
    logic                    w_wb_in, w_wb_lat, w_ld_done;

    assign w_mem_op  = ieu_mem_ren | ieu_mem_wen;
    assign w_is_load = ieu_mem_ren;

`ifdef BRQ_LDST_MISALIGN_TRAP_EN
    logic r_misaligned;
    assign w_trap = (r_state == ST_IDLE) & w_mem_op & acc_misaligned(ieu_func3, ieu_mem_addr[1:0]);
    assign ldst_misaligned = r_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    assign w_issue = (r_state == ST_IDLE) & w_mem_op & ~w_trap;

    ldst_align u_align (
        .i_st_func3   (ieu_func3),
        .i_st_addr_lo (ieu_mem_addr[1:0]),
        .i_st_data    (ieu_store_data),
        .o_st_be      (w_st_be),
        .o_st_wdata   (w_st_wdata),
        .i_ld_func3   (r_lat_func3),
        .i_ld_addr_lo (r_lat_addr[1:0]),
        .i_ld_rdata   (dmem_rdata),
        .o_ld_result  (w_ld_result)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_be        = 4'b0000;
        w_addr      = '0;
        w_wdata     = '0;
        w_stall     = 1'b0;
        w_wb_in     = 1'b0;
        w_wb_lat    = 1'b0;
        w_ld_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_req   = 1'b1;
                    w_we    = ~w_is_load;
                    w_be    = w_st_be;
                    w_addr  = {ieu_mem_addr[DataWidth-1:2], 2'b00};
                    w_wdata = w_st_wdata;
                    if (!dmem_gnt) begin
                        w_state_nxt = ST_REQ;
                        w_stall     = 1'b1;
                    end else if (w_is_load) begin
                        w_state_nxt = ST_WAIT_RD;
                        w_stall     = 1'b1;
                    end else begin
                        w_wb_in = 1'b1;
                    end
                end else begin
                    w_wb_in = 1'b1;
                end
            end
            ST_REQ: begin
                w_req   = 1'b1;
                w_we    = ~r_lat_load;
                w_be    = r_lat_be;
                w_addr  = {r_lat_addr[DataWidth-1:2], 2'b00};
                w_wdata = r_lat_wdata;
                if (!dmem_gnt) begin
                    w_stall = 1'b1;
                end else if (r_lat_load) begin
                    w_state_nxt = ST_WAIT_RD;
                    w_stall     = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_wb_lat    = 1'b1;
                end
            end
            ST_WAIT_RD: begin
                if (dmem_rvalid) begin
                    w_state_nxt = ST_IDLE;
                    w_wb_lat    = 1'b1;
                    w_ld_done   = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_state          <= ST_IDLE;
            r_lat_addr       <= '0;
            r_lat_func3      <= '0;
            r_lat_wdata      <= '0;
            r_lat_be         <= '0;
            r_lat_load       <= 1'b0;
            r_lat_regfile_en <= 1'b0;
            r_lat_memtoreg   <= 1'b0;
            r_lat_rd         <= '0;
            r_lat_alu        <= '0;
            r_regfile_en     <= 1'b0;
            r_addr_dst       <= '0;
            r_memtoreg       <= 1'b0;
            r_mem_result     <= '0;
            r_alu_result     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) begin
                r_lat_addr       <= ieu_mem_addr;
                r_lat_func3      <= ieu_func3;
                r_lat_wdata      <= w_st_wdata;
                r_lat_be         <= w_st_be;
                r_lat_load       <= w_is_load;
                r_lat_regfile_en <= ieu_regfile_en;
                r_lat_memtoreg   <= ieu_memtoreg;
                r_lat_rd         <= ieu_addr_dst;
                r_lat_alu        <= ieu_alu_result_dealy;
            end
            // A trapped access retires as a bubble: no write-back.
            if (w_wb_in) begin
                r_regfile_en <= ieu_regfile_en & ~w_trap;
                r_addr_dst   <= ieu_addr_dst;
                r_memtoreg   <= ieu_memtoreg;
                r_alu_result <= ieu_alu_result_dealy;
            end else if (w_wb_lat) begin
                r_regfile_en <= r_lat_regfile_en;
                r_addr_dst   <= r_lat_rd;
                r_memtoreg   <= r_lat_memtoreg;
                r_alu_result <= r_lat_alu;
                if (w_ld_done) begin
                    r_mem_result <= w_ld_result;
                end
            end else begin
                r_regfile_en <= 1'b0;
            end
        end
    end

`ifdef BRQ_LDST_MISALIGN_TRAP_EN
    always_ff @(posedge brq_clk) begin
        if (brq_rst) begin
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= w_trap;
        end
    end
`endif

    assign dmem_req        = w_req & ~brq_rst;
    assign ldst_stall      = w_stall & ~brq_rst;
    assign dmem_we         = w_we;
    assign dmem_be         = w_be;
    assign dmem_addr       = w_addr;
    assign dmem_wdata      = w_wdata;
    assign ldst_regfile_en = r_regfile_en;
    assign ldst_addr_dst   = r_addr_dst;
    assign ldst_memtoreg   = r_memtoreg;
    assign ldst_mem_result = r_mem_result;
    assign ldst_alu_result = r_alu_result;

endmodule
